pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 12: PC and target width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: return-address stack entries, power of two, at least 2.
REQ-003 SHALL have parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock; all state updates on this edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-low reset; 0 means reset.
REQ-006 SHALL have port en, input, 1 bit: advance enable; 0 means hold all state.
REQ-007 SHALL have port branch, input, 1 bit: taken branch/jump; next PC = target.
REQ-008 SHALL have port call, input, 1 bit: push pc+1 and next PC = target.
REQ-009 SHALL have port ret, input, 1 bit: pop; next PC = popped address.
REQ-010 SHALL have port target, input, WIDTH bits: redirect address for branch/call.
REQ-011 SHALL have port pc, output, WIDTH bits: current PC, registered.
REQ-012 SHALL have port pc_plus1, output, WIDTH bits: combinational pc+1 mod 2^WIDTH.
REQ-013 SHALL have port depth, output, clog2(DEPTH)+1 bits: valid stack entries, 0..DEPTH.
REQ-014 SHALL have port ovf, output, 1 bit: registered one-cycle pulse, push while full.
REQ-015 SHALL have port unf, output, 1 bit: registered one-cycle pulse, pop while empty.

Function
REQ-016 SHALL treat all control inputs as don't-care when en=0: pc, stack, and depth held; ovf/unf driven 0 next cycle.
REQ-017 SHALL, with en=1, select next PC by priority: ret > call > branch > pc+1.
REQ-018 SHALL on ret with depth>0 load pc from the top entry and decrement depth, in one cycle.
REQ-019 SHALL on ret with depth=0 load pc with pc+1, leave depth at 0, and pulse unf.
REQ-020 SHALL on call (ret=0) load pc with target, write pc+1 (value before the edge) to the top, and increment depth.
REQ-021 SHALL on call with depth=DEPTH overwrite the oldest entry (circular top pointer), keep depth=DEPTH, and pulse ovf.
REQ-022 SHALL on call and ret together (tail call) load pc with target, replace the top entry with pc+1, and leave depth unchanged; this applies only when depth>0.
REQ-023 SHALL on call and ret together with depth=0 behave as a plain call; unf stays 0.
REQ-024 SHALL on branch alone load pc with target; stack unchanged.
REQ-025 SHALL on no redirect load pc with pc+1; pc+1 from all-ones wraps to 0.
REQ-026 SHALL keep the stack top pointer modulo DEPTH; pop after overflow returns the most recent DEPTH pushes in LIFO order.
REQ-027 SHALL update every output 1 cycle after the qualifying edge, except pc_plus1, which is combinational from pc.

Reset
REQ-028 SHALL on reset=0 immediately, without a clock, set pc=RESET_VEC, depth=0, ovf=0, unf=0, and top pointer=0; stack contents are don't-care.
REQ-029 SHALL hold reset state while reset=0 regardless of clk and en; the first update occurs at the first rising edge after deassertion.
REQ-030 SHALL abort any in-flight redirect when reset is asserted mid-cycle; no partial push or pop survives.

Verification
REQ-031 Reset then 5 cycles en=1 with no controls: pc 0->1->2->3->4->5; pc_plus1=6; depth=0.
REQ-032 With pc=0x010, call target=0x100, then 3 increments, then ret: pc goes 0x100, 0x101, 0x102, 0x103, then 0x011; depth goes 1 then 0.
REQ-033 Five calls with DEPTH=4 from pcs 1,2,3,4,5: fifth call pulses ovf and depth=4; four rets return 6,5,4,3; a fifth ret pulses unf and pc=pc+1.
REQ-034 With pc=0xFFF and WIDTH=12, en=1: pc=0x000. With en=0 and call=1 asserted: pc, depth unchanged; ovf=0.
REQ-035 With depth=1 and top=0x020 at pc=0x050, call+ret with target=0x300: pc=0x300, top=0x051, depth=1; a later ret gives pc=0x051.
REQ-036 With depth=2, drop reset asynchronously between edges: pc=RESET_VEC, depth=0 before the next edge; after release, ret pulses unf.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack.
// Priority per cycle: ret > call > branch > sequential increment.
module pc_stack_unit #(
  parameter int unsigned      WIDTH     = 12,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    branch,
  input  logic                    call,
  input  logic                    ret,
  input  logic [WIDTH-1:0]        target,
  output logic [WIDTH-1:0]        pc,
  output logic [WIDTH-1:0]        pc_plus1,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    ovf,
  output logic                    unf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = PW + 1;
  localparam logic [DW-1:0] FullCount = DW'(DEPTH);

  typedef enum logic [2:0] {
    OpHold,
    OpInc,
    OpBranch,
    OpCall,
    OpRet,
    OpTail,
    OpUnf
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [PW-1:0]    tp_q, tp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    tp_m1;
  logic             empty;
  logic             full;
  op_e              op;

  assign pc_plus1 = pc_q + WIDTH'(1);
  assign tp_m1    = tp_q - PW'(1);
  assign empty    = (depth_q == '0);
  assign full     = (depth_q == FullCount);

  // A ret on an empty stack defers to call if one is present, else it underflows.
  always_comb begin
    op = OpHold;
    if (en) begin
      if (ret && !empty) begin
        op = call ? OpTail : OpRet;
      end else if (call) begin
        op = OpCall;
      end else if (ret) begin
        op = OpUnf;
      end else if (branch) begin
        op = OpBranch;
      end else begin
        op = OpInc;
      end
    end
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    tp_d    = tp_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = tp_q;
    unique case (op)
      OpHold: ;
      OpInc: begin
        pc_d = pc_plus1;
      end
      OpBranch: begin
        pc_d = target;
      end
      OpCall: begin
        pc_d   = target;
        wr_en  = 1'b1;
        wr_idx = tp_q;
        tp_d   = tp_q + PW'(1);
        // When full, tp_q already points at the oldest entry, so it is overwritten.
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          depth_d = depth_q + DW'(1);
        end
      end
      OpRet: begin
        pc_d    = stk_q[tp_m1];
        tp_d    = tp_m1;
        depth_d = depth_q - DW'(1);
      end
      OpTail: begin
        pc_d   = target;
        wr_en  = 1'b1;
        wr_idx = tp_m1;
      end
      OpUnf: begin
        pc_d  = pc_plus1;
        unf_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      tp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      tp_q    <= tp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries carry no reset; depth_q alone decides which ones are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stk_q[wr_idx] <= pc_plus1;
    end
  end

  assign pc    = pc_q;
  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed vector table, reset corner cases, and
// randomized traffic checked against a queue-based return-stack model.
module tb_pc_stack_unit;

  localparam int unsigned W = 12;
  localparam int unsigned D = 4;

  logic          clk;
  logic          reset;
  logic          en;
  logic          branch;
  logic          call;
  logic          ret;
  logic [W-1:0]  target;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_plus1;
  logic [2:0]    depth;
  logic          ovf;
  logic          unf;

  int checks = 0;
  int errors = 0;

  pc_stack_unit #(
    .WIDTH    (W),
    .DEPTH    (D),
    .RESET_VEC(12'h000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .branch  (branch),
    .call    (call),
    .ret     (ret),
    .target  (target),
    .pc      (pc),
    .pc_plus1(pc_plus1),
    .depth   (depth),
    .ovf     (ovf),
    .unf     (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: return addresses in a bounded queue, newest at the back.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_ovf;
  logic         m_unf;

  task automatic model_reset();
    m_pc = 12'h000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic b, input logic c, input logic r,
                            input logic [W-1:0] t);
    logic [W-1:0] nxt;
    nxt   = m_pc + 12'd1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!e) return;
    if (r && m_stk.size() > 0 && c) begin
      m_stk[m_stk.size()-1] = nxt;
      m_pc = t;
    end else if (r && m_stk.size() > 0) begin
      m_pc = m_stk.pop_back();
    end else if (c) begin
      m_stk.push_back(nxt);
      if (m_stk.size() > D) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = t;
    end else if (r) begin
      m_pc  = nxt;
      m_unf = 1'b1;
    end else if (b) begin
      m_pc = t;
    end else begin
      m_pc = nxt;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic b, input logic c, input logic r,
                     input logic [W-1:0] t);
    @(negedge clk);
    en = e; branch = b; call = c; ret = r; target = t;
    @(posedge clk);
    model_step(e, b, c, r, t);
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic [W-1:0] p1;
    p1 = m_pc + 12'd1;
    chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
    chk({tag, "_pc_plus1"}, 32'(pc_plus1), 32'(p1));
    chk({tag, "_depth"}, 32'(depth), 32'(m_stk.size()));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(unf), 32'(m_unf));
  endtask

  typedef struct {
    logic         e, b, c, r;
    logic [W-1:0] t;
    logic [W-1:0] pc;
    logic [2:0]   depth;
    logic         ovf, unf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic e, input logic b, input logic c, input logic r,
                             input logic [W-1:0] t, input logic [W-1:0] p,
                             input logic [2:0] d, input logic o, input logic u);
    vec_t x;
    x.e = e; x.b = b; x.c = c; x.r = r; x.t = t;
    x.pc = p; x.depth = d; x.ovf = o; x.unf = u;
    return x;
  endfunction

  initial begin
    // Sequential run, then call/ret round trip from 0x010.
    for (int i = 1; i <= 5; i++) vt.push_back(v(1, 0, 0, 0, 12'h000, 12'(i), 0, 0, 0));
    vt.push_back(v(1, 1, 0, 0, 12'h010, 12'h010, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 12'h100, 12'h100, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 12'h000, 12'h101, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 12'h000, 12'h102, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 12'h000, 12'h103, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h011, 0, 0, 0));
    // Five calls from pcs 1..5, overflow on the fifth, then drain plus one underflow.
    vt.push_back(v(1, 1, 0, 0, 12'h001, 12'h001, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 12'h002, 12'h002, 1, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 12'h003, 12'h003, 2, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 12'h004, 12'h004, 3, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 12'h005, 12'h005, 4, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 12'h200, 12'h200, 4, 1, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h006, 3, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h005, 2, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h004, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h003, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h004, 0, 0, 1));
    vt.push_back(v(1, 0, 0, 0, 12'h000, 12'h005, 0, 0, 0));
    // Wrap at all-ones, then en=0 holds everything.
    vt.push_back(v(1, 1, 0, 0, 12'hFFF, 12'hFFF, 0, 0, 0));
    vt.push_back(v(1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0));
    vt.push_back(v(0, 0, 1, 0, 12'h123, 12'h000, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0));
    // Tail call with depth 1, then tail call on empty stack acts as plain call.
    vt.push_back(v(1, 1, 0, 0, 12'h01F, 12'h01F, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 0, 12'h050, 12'h050, 1, 0, 0));
    vt.push_back(v(1, 0, 1, 1, 12'h300, 12'h300, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h051, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 1, 12'h400, 12'h400, 1, 0, 0));
    vt.push_back(v(1, 0, 0, 1, 12'h000, 12'h052, 0, 0, 0));
    // Priority: call beats branch, ret beats branch.
    vt.push_back(v(1, 1, 1, 0, 12'h500, 12'h500, 1, 0, 0));
    vt.push_back(v(1, 1, 0, 1, 12'h7AA, 12'h053, 0, 0, 0));

    en = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; target = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset_async_pc", 32'(pc), 32'h000);
    chk("reset_async_depth", 32'(depth), 32'd0);
    chk("reset_async_flags", 32'({ovf, unf}), 32'd0);

    // Clocks with en=1 and call=1 while reset is held must change nothing.
    en = 1'b1; call = 1'b1; target = 12'h3C3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold_pc", 32'(pc), 32'h000);
    chk("reset_hold_depth", 32'(depth), 32'd0);
    @(negedge clk);
    en = 1'b0; call = 1'b0;
    reset = 1'b1;
    model_reset();

    foreach (vt[i]) begin
      logic [W-1:0] p1;
      cyc(vt[i].e, vt[i].b, vt[i].c, vt[i].r, vt[i].t);
      p1 = vt[i].pc + 12'd1;
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vt[i].pc));
      chk($sformatf("vec%0d_pc_plus1", i), 32'(pc_plus1), 32'(p1));
      chk($sformatf("vec%0d_depth", i), 32'(depth), 32'(vt[i].depth));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
      chk($sformatf("vec%0d_unf", i), 32'(unf), 32'(vt[i].unf));
    end

    // Mid-cycle reset with two entries on the stack and a call pending.
    cyc(1, 0, 1, 0, 12'h600);
    cyc(1, 0, 1, 0, 12'h700);
    chk("pre_reset_depth", 32'(depth), 32'd2);
    chk("pre_reset_pc", 32'(pc), 32'h700);
    @(negedge clk);
    en = 1'b1; call = 1'b1; target = 12'h654;
    #2 reset = 1'b0;
    #1;
    chk("midcycle_reset_pc", 32'(pc), 32'h000);
    chk("midcycle_reset_depth", 32'(depth), 32'd0);
    @(posedge clk);
    #1;
    chk("midcycle_hold_pc", 32'(pc), 32'h000);
    chk("midcycle_hold_depth", 32'(depth), 32'd0);
    @(negedge clk);
    en = 1'b0; call = 1'b0;
    reset = 1'b1;
    model_reset();
    cyc(1, 0, 0, 1, 12'h000);
    chk("post_reset_ret_unf", 32'(unf), 32'd1);
    chk("post_reset_ret_pc", 32'(pc), 32'h001);
    chk("post_reset_ret_depth", 32'(depth), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic e, b, c, r;
      logic [W-1:0] t;
      e = ($urandom_range(0, 9) != 0);
      b = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      t = 12'($urandom);
      cyc(e, b, c, r, t);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
